// File: rtl/ddr3_ui_bridge.sv
// Client-to-MIG UI bridge: one command per accept, independent cmd/wdata handshakes,
// up to MAX_OUTSTANDING in-order reads whose lane tags ride a small FIFO.
module ddr3_ui_bridge #(
  parameter int ADDR_W          = 29,
  parameter int APP_DATA_W      = 64,
  parameter int CLIENT_W        = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int LANES  = APP_DATA_W / CLIENT_W,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int TAG_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int CNT_W  = TAG_W + 1,
  localparam int BE_W   = CLIENT_W / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LANE_W-1:0]       req_lane,
  input  logic [CLIENT_W-1:0]     req_wdata,
  input  logic [BE_W-1:0]         req_be,
  output logic                    rsp_valid,
  output logic [CLIENT_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]       app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [APP_DATA_W-1:0]   app_wdf_data,
  output logic [APP_DATA_W/8-1:0] app_wdf_mask,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  input  logic                    app_wdf_rdy,
  input  logic [APP_DATA_W-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    err_unexpected
);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t state, state_next;

  logic [LANE_W-1:0]       tag_mem [MAX_OUTSTANDING];
  logic [TAG_W-1:0]        wr_ptr, rd_ptr;
  logic                    accept, push, pop;
  logic                    cmd_pend, data_pend;
  logic [LANE_W-1:0]       head_lane;
  logic [CLIENT_W-1:0]     lane_data;
  logic [APP_DATA_W/8-1:0] mask_next;

  assign accept    = req_valid && req_ready;
  assign push      = accept && !req_we;
  assign pop       = app_rd_data_valid && (outstanding != '0);
  // Pending after this edge: the handshake that completes this cycle no longer counts
  assign cmd_pend  = app_en && !app_rdy;
  assign data_pend = app_wdf_wren && !app_wdf_rdy;
  assign head_lane = tag_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (!cmd_pend && !data_pend) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && (outstanding < CNT_W'(MAX_OUTSTANDING));
  end

  always_comb begin
    mask_next = '1;
    for (int i = 0; i < LANES; i++) begin
      if (req_lane == LANE_W'(i)) mask_next[i*BE_W +: BE_W] = ~req_be;
    end
  end

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (head_lane == LANE_W'(i)) lane_data = app_rd_data[i*CLIENT_W +: CLIENT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_addr     <= '0;
      app_cmd      <= CMD_WRITE;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '1;
      app_wdf_wren <= 1'b0;
    end else if (accept) begin
      app_addr <= req_addr;
      app_cmd  <= req_we ? CMD_WRITE : CMD_READ;
      app_en   <= 1'b1;
      if (req_we) begin
        app_wdf_data <= {LANES{req_wdata}};
        app_wdf_mask <= mask_next;
        app_wdf_wren <= 1'b1;
      end
    end else begin
      if (app_en && app_rdy)           app_en       <= 1'b0;
      if (app_wdf_wren && app_wdf_rdy) app_wdf_wren <= 1'b0;
    end
  end

  // Single-beat bursts: every data beat is also the last one
  assign app_wdf_end = app_wdf_wren;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= req_lane;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + TAG_W'(1);
      if (pop)  rd_ptr <= rd_ptr + TAG_W'(1);
      case ({push, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      err_unexpected <= 1'b0;
    end else begin
      rsp_valid <= pop;
      if (pop) rsp_rdata <= lane_data;
      if (app_rd_data_valid && (outstanding == '0)) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_ui_bridge.sv
// Scenario bench for ddr3_ui_bridge: expected read data is queued when returns are driven
// and compared by a response monitor; UI-side outputs are checked inline per scenario.
module tb_ddr3_ui_bridge;

  localparam int ADDR_W = 29;
  localparam int APP_W  = 64;
  localparam int CW     = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [0:0]        req_lane;
  logic [CW-1:0]     req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic [CW-1:0]     rsp_rdata;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en, app_rdy;
  logic [APP_W-1:0]  app_wdf_data;
  logic [7:0]        app_wdf_mask;
  logic              app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [APP_W-1:0]  app_rd_data;
  logic              app_rd_data_valid;
  logic [2:0]        outstanding;
  logic              err_unexpected;

  int errors = 0;
  int checks = 0;
  logic [0:0]    lane_q[$];
  logic [CW-1:0] exp_q[$];

  ddr3_ui_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_lane(req_lane), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Response monitor: every rsp_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_rdata=%h with no expected response", rsp_rdata);
      end else begin
        automatic logic [CW-1:0] e = exp_q.pop_front();
        if (rsp_rdata !== e) begin
          errors++;
          $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [0:0] lane,
                       input logic [CW-1:0] wdata, input logic [3:0] be);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_lane = lane;
    req_wdata = wdata; req_be = be;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL issue_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
      req_valid = 1'b0;
      return;
    end
    step();
    req_valid = 1'b0;
    if (!we) lane_q.push_back(lane);
  endtask

  task automatic return_beat(input logic [APP_W-1:0] data);
    logic [0:0] l;
    if (lane_q.size() != 0) begin
      l = lane_q.pop_front();
      exp_q.push_back(data[l*CW +: CW]);
    end
    app_rd_data = data;
    app_rd_data_valid = 1'b1;
    step();
    app_rd_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, rsp_valid, err_unexpected, req_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags: got en/wren/end/rsp/err/rdy=%b required 000001",
               {app_en, app_wdf_wren, app_wdf_end, rsp_valid, err_unexpected, req_ready});
    end
    checks++;
    if ({app_cmd, app_addr, app_wdf_data, rsp_rdata, outstanding} !== '0) begin
      errors++;
      $display("FAIL reset_zero: cmd=%h addr=%h data=%h rdata=%h outst=%0d required all 0",
               app_cmd, app_addr, app_wdf_data, rsp_rdata, outstanding);
    end
    checks++;
    if (app_wdf_mask !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mask: got %h required ff", app_wdf_mask);
    end
  endtask

  task automatic test_write();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    issue(1'b1, 29'h100, 1'b1, 32'hDEADBEEF, 4'b1111);
    checks++;
    if ({app_en, app_cmd, app_wdf_wren, app_wdf_end, req_ready} !== 7'b1_000_110) begin
      errors++;
      $display("FAIL write_ctrl: got en/cmd/wren/end/rdy=%b required 1000110",
               {app_en, app_cmd, app_wdf_wren, app_wdf_end, req_ready});
    end
    checks++;
    if ({app_addr, app_wdf_mask, app_wdf_data} !== {29'h100, 8'h0F, 64'hDEADBEEF_DEADBEEF}) begin
      errors++;
      $display("FAIL write_payload: addr=%h mask=%h data=%h required 100/0f/deadbeefdeadbeef",
               app_addr, app_wdf_mask, app_wdf_data);
    end
    step();
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL write_done: got en/wren/end/rdy=%b required 0001",
               {app_en, app_wdf_wren, app_wdf_end, req_ready});
    end
  endtask

  task automatic test_split_handshake();
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    issue(1'b1, 29'h200, 1'b0, 32'h12345678, 4'b1111);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) app_wdf_rdy = 1'b1;
      checks++;
      if ({app_en, app_wdf_wren, req_ready} !== {(k == 1), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL split_data_late c%0d: got en/wren/rdy=%b required %b", k,
                 {app_en, app_wdf_wren, req_ready}, {(k == 1), 2'b10});
      end
      step();
    end
    checks++;
    if ({app_en, app_wdf_wren, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL split_data_late_end: got en/wren/rdy=%b required 001",
               {app_en, app_wdf_wren, req_ready});
    end
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    issue(1'b1, 29'h204, 1'b1, 32'h9ABCDEF0, 4'b1111);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) app_rdy = 1'b1;
      checks++;
      if ({app_en, app_wdf_wren, req_ready} !== {1'b1, (k == 1), 1'b0}) begin
        errors++;
        $display("FAIL split_cmd_late c%0d: got en/wren/rdy=%b required %b", k,
                 {app_en, app_wdf_wren, req_ready}, {1'b1, (k == 1), 1'b0});
      end
      step();
    end
    checks++;
    if ({app_en, app_wdf_wren, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL split_cmd_late_end: got en/wren/rdy=%b required 001",
               {app_en, app_wdf_wren, req_ready});
    end
  endtask

  task automatic test_byte_mask();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    issue(1'b1, 29'h300, 1'b0, 32'hCAFEF00D, 4'b0101);
    checks++;
    if (app_wdf_mask !== 8'hFA) begin
      errors++;
      $display("FAIL mask_0101_lane0: got %h required fa", app_wdf_mask);
    end
    step();
    issue(1'b1, 29'h304, 1'b1, 32'h0, 4'b0000);
    checks++;
    if ({app_wdf_mask, app_wdf_wren, app_en} !== {8'hFF, 2'b11}) begin
      errors++;
      $display("FAIL mask_zero_be: got mask=%h wren=%b en=%b required ff/1/1",
               app_wdf_mask, app_wdf_wren, app_en);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 29'h400; req_lane = 1'b0;
    req_wdata = 32'h55AA55AA; req_be = 4'hF;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (app_en) n++;
    end
    req_valid = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL back_to_back: got %0d commands in 8 cycles required 4", n);
    end
    step();
    step();
  endtask

  task automatic test_pipelined_reads();
    logic [0:0] lanes [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    app_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 29'h500 + 29'(i), lanes[i], 32'h0, 4'h0);
      if (i == 0) begin
        checks++;
        if ({app_en, app_cmd, app_wdf_wren} !== 5'b1_001_0) begin
          errors++;
          $display("FAIL read_cmd: got en/cmd/wren=%b required 10010", {app_en, app_cmd, app_wdf_wren});
        end
      end
    end
    step();
    req_valid = 1'b1; req_we = 1'b0; req_lane = 1'b0; req_addr = 29'h600;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({req_ready, outstanding} !== {1'b0, 3'd4}) begin
        errors++;
        $display("FAIL read_stall c%0d: got rdy=%b outst=%0d required 0/4", k, req_ready, outstanding);
      end
      step();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) return_beat(64'h11111111_22222222);
    step();
    step();
    checks++;
    if ({outstanding, req_ready} !== {3'd0, 1'b1} || exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_drain: got outst=%0d rdy=%b pending=%0d required 0/1/0",
               outstanding, req_ready, exp_q.size());
    end
  endtask

  task automatic test_push_pop();
    logic [0:0] l;
    app_rdy = 1'b1;
    issue(1'b0, 29'h700, 1'b1, 32'h0, 4'h0);
    step();
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 29'h710 + 29'(i); req_lane = 1'(i);
      app_rd_data = {32'hB0000000 + 32'(i), 32'hA0000000 + 32'(i)};
      app_rd_data_valid = 1'b1;
      l = lane_q.pop_front();
      exp_q.push_back(app_rd_data[l*CW +: CW]);
      lane_q.push_back(1'(i));
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL pushpop_ready i%0d: got %b required 1", i, req_ready);
      end
      step();
      req_valid = 1'b0; app_rd_data_valid = 1'b0;
      checks++;
      if (outstanding !== 3'd1) begin
        errors++;
        $display("FAIL pushpop_outst i%0d: got %0d required 1", i, outstanding);
      end
      step();
    end
    return_beat(64'hC0C0C0C0_D1D1D1D1);
    step();
    checks++;
    if (outstanding !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL pushpop_drain: got outst=%0d pending=%0d required 0/0", outstanding, exp_q.size());
    end
  endtask

  task automatic test_spurious();
    checks++;
    if ({err_unexpected, outstanding} !== 4'b0_000) begin
      errors++;
      $display("FAIL spur_pre: got err=%b outst=%0d required 0/0", err_unexpected, outstanding);
    end
    return_beat(64'hFFFF0000_0000FFFF);
    checks++;
    if ({rsp_valid, err_unexpected} !== 2'b01) begin
      errors++;
      $display("FAIL spur_flag: got rsp_valid/err=%b required 01", {rsp_valid, err_unexpected});
    end
    step();
    step();
    checks++;
    if ({err_unexpected, outstanding} !== 4'b1_000) begin
      errors++;
      $display("FAIL spur_sticky: got err=%b outst=%0d required 1/0", err_unexpected, outstanding);
    end
  endtask

  task automatic test_reset_mid();
    app_rdy = 1'b1;
    issue(1'b0, 29'h800, 1'b0, 32'h0, 4'h0);
    step();
    issue(1'b0, 29'h801, 1'b1, 32'h0, 4'h0);
    step();
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    issue(1'b1, 29'h802, 1'b1, 32'h87654321, 4'h3);
    checks++;
    if ({app_en, app_wdf_wren, outstanding} !== {2'b11, 3'd2}) begin
      errors++;
      $display("FAIL rstmid_pre: got en/wren=%b outst=%0d required 11/2", {app_en, app_wdf_wren}, outstanding);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    lane_q.delete();
    exp_q.delete();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_lane = '0; req_wdata = '0; req_be = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();
    test_write();
    test_split_handshake();
    test_byte_mask();
    test_back_to_back();
    test_pipelined_reads();
    test_push_pop();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
